// File: rtl/multi_port_queueing_domain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_port_queueing_domain: N-port ingress routed into per-core FIFOs    |
// | with per-queue round-robin. Optional: MEMOREDF_WATERMARK_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
module multi_port_queueing_domain #(
  parameter  int NUM_PORTS        = 2,
  parameter  int NUMBER_OF_QUEUES = 4,
  parameter  int QUEUE_LENGTH     = 16,
  parameter  int DATA_SIZE        = 678,
  parameter  int REGISTER_SIZE    = 32,
  localparam int QID_W            = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUM_PORTS-1:0][DATA_SIZE-1:0]              in_packet,
  input  logic [NUM_PORTS-1:0]                             in_valid,
  input  logic [NUM_PORTS-1:0][QID_W-1:0]                  in_id,
  output logic [NUM_PORTS-1:0]                             in_ready,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   thresholds,
  input  logic [QID_W-1:0]                                 sel_id,
  input  logic                                             consumed,
  output logic [DATA_SIZE-1:0]                             out_packet,
  output logic                                             out_valid,
  output logic [NUMBER_OF_QUEUES-1:0]                      empty,
  output logic [NUMBER_OF_QUEUES-1:0]                      full,
  output logic [NUMBER_OF_QUEUES-1:0]                      last_elem,
  output logic [NUMBER_OF_QUEUES-1:0]                      kill_the_core,
`ifdef MEMOREDF_WATERMARK_EN
  input  logic                                             watermark_clear,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   watermark,
`endif
  output logic                                             bad_id
);

  localparam int PTR_W = $clog2(QUEUE_LENGTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_SIZE-1:0]                       mem_q [NUMBER_OF_QUEUES][QUEUE_LENGTH];
  logic [NUMBER_OF_QUEUES-1:0][PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [NUMBER_OF_QUEUES-1:0][CNT_W-1:0]     count_q, count_d;
  logic [NUMBER_OF_QUEUES-1:0][RR_W-1:0]      rr_q, rr_d;
  logic [NUMBER_OF_QUEUES-1:0]                kill_q, kill_d;
  logic                                       bad_id_q, bad_id_d;
  logic [NUMBER_OF_QUEUES-1:0]                push, pop, full_w;
  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] wdata;
  logic [NUM_PORTS-1:0]                       id_bad;

  // Out-of-range ids only exist when the queue count is not a power of two.
  generate
    if ((1 << QID_W) == NUMBER_OF_QUEUES) begin : g_pow2_ids
      assign id_bad = '0;
    end else begin : g_npow2_ids
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_chk
        assign id_bad[p] = (in_id[p] >= QID_W'(NUMBER_OF_QUEUES));
      end
    end
  endgenerate

  always_comb begin
    int   idx;
    int   win;
    logic found;
    in_ready = '0;
    push     = '0;
    full_w   = '0;
    wdata    = '0;
    rr_d     = rr_q;
    idx      = 0;
    win      = 0;
    found    = 1'b0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      full_w[q] = (count_q[q] == CNT_W'(QUEUE_LENGTH));
      found     = 1'b0;
      win       = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr_q[q]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && in_valid[idx] && !id_bad[idx] && (in_id[idx] == QID_W'(q))) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && !full_w[q]) begin
        push[q]       = 1'b1;
        in_ready[win] = 1'b1;
        wdata[q]      = in_packet[win];
        rr_d[q]       = (win + 1 >= NUM_PORTS) ? '0 : RR_W'(win + 1);
      end
    end
    in_ready = in_ready | id_bad;
  end

  always_comb begin
    pop        = '0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    kill_d     = '0;
    empty      = '0;
    full       = '0;
    last_elem  = '0;
    out_packet = '0;
    out_valid  = 1'b0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      pop[q]       = consumed && (sel_id == QID_W'(q)) && (count_q[q] != '0);
      head_d[q]    = pop[q]  ? head_q[q] + PTR_W'(1) : head_q[q];
      tail_d[q]    = push[q] ? tail_q[q] + PTR_W'(1) : tail_q[q];
      count_d[q]   = count_q[q] + CNT_W'(push[q]) - CNT_W'(pop[q]);
      kill_d[q]    = (thresholds[q] != '0) && (REGISTER_SIZE'(count_d[q]) > thresholds[q]);
      empty[q]     = (count_q[q] == '0);
      full[q]      = full_w[q];
      last_elem[q] = (count_q[q] == CNT_W'(1));
      if (sel_id == QID_W'(q)) begin
        out_packet = mem_q[q][head_q[q]];
        out_valid  = (count_q[q] != '0);
      end
    end
    bad_id_d = bad_id_q | (|(in_valid & id_bad));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      kill_q   <= '0;
      bad_id_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      kill_q   <= kill_d;
      bad_id_q <= bad_id_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      if (reset && push[q]) mem_q[q][tail_q[q]] <= wdata[q];
    end
  end

  assign kill_the_core = kill_q;
  assign bad_id        = bad_id_q;

`ifdef MEMOREDF_WATERMARK_EN
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] wm_q, wm_d;

  always_comb begin
    wm_d = wm_q;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      if (watermark_clear) begin
        wm_d[q] = REGISTER_SIZE'(count_q[q]);
      end else if (REGISTER_SIZE'(count_q[q]) > wm_q[q]) begin
        wm_d[q] = REGISTER_SIZE'(count_q[q]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) wm_q <= '0;
    else        wm_q <= wm_d;
  end

  assign watermark = wm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_port_queueing_domain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multi_port_queueing_domain: scoreboard bench for the queueing domain  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multi_port_queueing_domain;
  localparam int NP = 2;
  localparam int NQ = 4;
  localparam int QL = 16;
  localparam int DW = 678;
  localparam int RS = 32;
  localparam int QW = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NP-1:0][DW-1:0]  in_packet;
  logic [NP-1:0]          in_valid;
  logic [NP-1:0][QW-1:0]  in_id;
  logic [NP-1:0]          in_ready;
  logic [NQ-1:0][RS-1:0]  thresholds;
  logic [QW-1:0]          sel_id;
  logic                   consumed;
  logic [DW-1:0]          out_packet;
  logic                   out_valid;
  logic [NQ-1:0]          empty, full, last_elem, kill_the_core;
  logic                   bad_id;
`ifdef MEMOREDF_WATERMARK_EN
  logic                   watermark_clear;
  logic [NQ-1:0][RS-1:0]  watermark;
`endif

  multi_port_queueing_domain #(
    .NUM_PORTS(NP), .NUMBER_OF_QUEUES(NQ), .QUEUE_LENGTH(QL),
    .DATA_SIZE(DW), .REGISTER_SIZE(RS)
  ) dut (
    .clock(clock), .reset(reset),
    .in_packet(in_packet), .in_valid(in_valid), .in_id(in_id), .in_ready(in_ready),
    .thresholds(thresholds), .sel_id(sel_id), .consumed(consumed),
    .out_packet(out_packet), .out_valid(out_valid),
    .empty(empty), .full(full), .last_elem(last_elem), .kill_the_core(kill_the_core),
`ifdef MEMOREDF_WATERMARK_EN
    .watermark_clear(watermark_clear), .watermark(watermark),
`endif
    .bad_id(bad_id)
  );

  always #5 clock = ~clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] sb [NQ][$];
  int            cnt_m [NQ];
  int            rr_m  [NQ];
  int            wm_m  [NQ];
  int            seq   [NP];
  logic [NQ-1:0] kill_m;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int port, input int s);
    logic [DW-1:0] p;
    p = '0;
    p[31:0]      = 32'(port * 1000 + s);
    p[300 +: 16] = 16'(s * 3 + 1);
    p[DW-1 -: 32] = ~32'(s * 7919 + port);
    return p;
  endfunction

  task automatic status_check();
    logic [NQ-1:0] e_empty, e_full, e_last;
    for (int q = 0; q < NQ; q++) begin
      e_empty[q] = (cnt_m[q] == 0);
      e_full[q]  = (cnt_m[q] == QL);
      e_last[q]  = (cnt_m[q] == 1);
    end
    check("empty",     DW'(empty),         DW'(e_empty));
    check("full",      DW'(full),          DW'(e_full));
    check("last_elem", DW'(last_elem),     DW'(e_last));
    check("kill",      DW'(kill_the_core), DW'(kill_m));
    check("bad_id",    DW'(bad_id),        DW'(1'b0));
`ifdef MEMOREDF_WATERMARK_EN
    for (int q = 0; q < NQ; q++) check("watermark", DW'(watermark[q]), DW'(wm_m[q]));
`endif
  endtask

  // One clock of stimulus: drive, check against the model, clock, update model.
  task automatic step(input logic [1:0] v, input logic [QW-1:0] i0, input logic [QW-1:0] i1,
                      input logic cons, input logic [QW-1:0] sel);
    logic [QW-1:0] ids [NP];
    logic [NP-1:0] e_rdy;
    logic [NQ-1:0] grant;
    int            win [NQ];
    logic          found;
    int            p;
    @(negedge clock);
    ids[0] = i0;
    ids[1] = i1;
    in_valid     = v;
    in_id[0]     = i0;
    in_id[1]     = i1;
    in_packet[0] = mk(0, seq[0]);
    in_packet[1] = mk(1, seq[1]);
    consumed     = cons;
    sel_id       = sel;
    #1;
    e_rdy = '0;
    grant = '0;
    for (int q = 0; q < NQ; q++) begin
      found  = 1'b0;
      win[q] = 0;
      for (int k = 0; k < NP; k++) begin
        p = (rr_m[q] + k) % NP;
        if (!found && v[p] && (int'(ids[p]) == q)) begin
          found = 1'b1;
          if (cnt_m[q] < QL) begin
            e_rdy[p] = 1'b1;
            grant[q] = 1'b1;
            win[q]   = p;
          end
        end
      end
    end
    check("in_ready",  DW'(in_ready),  DW'(e_rdy));
    check("out_valid", DW'(out_valid), DW'(cnt_m[sel] != 0));
    if (cnt_m[sel] != 0) check("out_packet", out_packet, sb[sel][0]);
    @(posedge clock);
    for (int q = 0; q < NQ; q++) if (cnt_m[q] > wm_m[q]) wm_m[q] = cnt_m[q];
    if (cons && cnt_m[sel] > 0) begin
      void'(sb[sel].pop_front());
      cnt_m[sel]--;
    end
    for (int q = 0; q < NQ; q++) begin
      if (grant[q]) begin
        sb[q].push_back(mk(win[q], seq[win[q]]));
        seq[win[q]]++;
        cnt_m[q]++;
        rr_m[q] = (win[q] + 1) % NP;
      end
      kill_m[q] = (thresholds[q] != 0) && (cnt_m[q] > int'(thresholds[q]));
    end
    #1;
    status_check();
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = '0;
    in_id      = '0;
    in_packet  = '0;
    thresholds = '0;
    sel_id     = '0;
    consumed   = 1'b0;
`ifdef MEMOREDF_WATERMARK_EN
    watermark_clear = 1'b0;
`endif
    for (int q = 0; q < NQ; q++) begin
      cnt_m[q] = 0;
      rr_m[q]  = 0;
      wm_m[q]  = 0;
    end
    for (int p = 0; p < NP; p++) seq[p] = 0;
    kill_m = '0;

    repeat (3) @(posedge clock);
    #1;
    status_check();
    check("reset_out_valid", DW'(out_valid), DW'(1'b0));
    check("reset_empty",     DW'(empty),     DW'(4'hF));
    @(negedge clock);
    reset = 1'b1;

    // Two packets into q2 from port 0, then read them back in order.
    repeat (2) step(2'b01, 2'd2, 2'd0, 1'b0, 2'd2);
    step(2'b00, 2'd0, 2'd0, 1'b1, 2'd2);
    check("q2_last_after_pop", DW'(last_elem[2]), DW'(1'b1));
    step(2'b00, 2'd0, 2'd0, 1'b1, 2'd2);
    check("q2_empty_after_pops", DW'(empty[2]), DW'(1'b1));

    // Both ports contend for q1: grants alternate starting with port 0.
    repeat (4) step(2'b11, 2'd1, 2'd1, 1'b0, 2'd1);
    check("q1_not_full_4", DW'(full[1]), DW'(1'b0));
    repeat (4) step(2'b00, 2'd0, 2'd0, 1'b1, 2'd1);

    // Fill q3, then a push coinciding with a pop on the full queue is refused.
    repeat (QL) step(2'b10, 2'd0, 2'd3, 1'b0, 2'd3);
    check("q3_full", DW'(full[3]), DW'(1'b1));
    step(2'b10, 2'd0, 2'd3, 1'b1, 2'd3);
    step(2'b10, 2'd0, 2'd3, 1'b0, 2'd3);
    check("q3_full_again", DW'(full[3]), DW'(1'b1));
    repeat (QL) step(2'b00, 2'd0, 2'd0, 1'b1, 2'd3);

    // Kill threshold on q0.
    thresholds[0] = 32'd3;
    repeat (3) step(2'b01, 2'd0, 2'd0, 1'b0, 2'd0);
    check("kill_below", DW'(kill_the_core[0]), DW'(1'b0));
    step(2'b01, 2'd0, 2'd0, 1'b0, 2'd0);
    check("kill_rise", DW'(kill_the_core[0]), DW'(1'b1));
    step(2'b00, 2'd0, 2'd0, 1'b1, 2'd0);
    check("kill_fall", DW'(kill_the_core[0]), DW'(1'b0));
    step(2'b01, 2'd0, 2'd0, 1'b1, 2'd0);
    thresholds[0] = 32'd0;
    repeat (3) step(2'b01, 2'd0, 2'd0, 1'b0, 2'd0);
    check("kill_disabled", DW'(kill_the_core[0]), DW'(1'b0));
    repeat (6) step(2'b00, 2'd0, 2'd0, 1'b1, 2'd0);

    // Parallel writes to different queues, then drain both.
    step(2'b11, 2'd0, 2'd1, 1'b0, 2'd0);
    step(2'b11, 2'd2, 2'd1, 1'b1, 2'd0);
    repeat (2) step(2'b00, 2'd0, 2'd0, 1'b1, 2'd1);
    step(2'b00, 2'd0, 2'd0, 1'b1, 2'd2);

    // Consume on an empty queue must not move its pointers.
    repeat (2) step(2'b00, 2'd0, 2'd0, 1'b1, 2'd2);
    step(2'b01, 2'd2, 2'd0, 1'b0, 2'd2);
    step(2'b00, 2'd0, 2'd0, 1'b1, 2'd2);
    step(2'b00, 2'd0, 2'd0, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
